// File: rtl/output_buffer.sv
// Memory-mapped output buffer: LEDs, seven-segment digits and an LCD port whose
// writes are followed by a timed EN pulse.
//
// state | meaning
// IDLE  | no LCD transfer in flight; LCD writes accepted
// SETUP | LCD data latched, one cycle of bus settling before EN rises
// PULSE | EN high, cnt counts down the high phase
// HOLD  | EN low, cnt counts down the hold time before the next transfer
module output_buffer #(
  parameter int LCD_PULSE_CYC = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_buf_en,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} lcd_state_e;

  localparam logic [7:0] CNT_LOAD = 8'(LCD_PULSE_CYC - 1);

  logic [11:0] off;
  logic        busy;
  logic        lcd_start;
  lcd_state_e  state_q;
  logic [7:0]  cnt_q;
  logic        en_q;

  logic [16:0] ledr_q, ledr_d;
  logic [7:0]  ledg_q, ledg_d;
  logic [6:0]  hex_q [8];
  logic [6:0]  hex_d [8];
  logic [10:0] lcd_q, lcd_d;

  logic unused_bits;
  assign unused_bits = ^{i_lsu_addr[31:12], i_st_data[31], i_st_data[23],
                         i_st_data[15], i_st_data[7]};

  assign off       = i_lsu_addr[11:0];
  assign busy      = (state_q != S_IDLE);
  assign lcd_start = i_buf_en && (off == 12'h030) && (i_bmask[0] || i_bmask[1]) && !busy;

  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    lcd_d  = lcd_q;
    for (int k = 0; k < 8; k++) hex_d[k] = hex_q[k];
    if (i_buf_en) begin
      case (off)
        12'h000: begin
          if (i_bmask[0]) ledr_d[7:0]  = i_st_data[7:0];
          if (i_bmask[1]) ledr_d[15:8] = i_st_data[15:8];
          if (i_bmask[2]) ledr_d[16]   = i_st_data[16];
        end
        12'h010: if (i_bmask[0]) ledg_d = i_st_data[7:0];
        12'h020: for (int k = 0; k < 4; k++)
                   if (i_bmask[k]) hex_d[k] = i_st_data[8*k +: 7];
        12'h024: for (int k = 0; k < 4; k++)
                   if (i_bmask[k]) hex_d[k+4] = i_st_data[8*k +: 7];
        12'h030: if (lcd_start) begin
          if (i_bmask[0]) lcd_d[7:0]  = i_st_data[7:0];
          if (i_bmask[1]) lcd_d[10:8] = i_st_data[10:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      for (int k = 0; k < 8; k++) hex_q[k] <= '0;
    end else begin
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      lcd_q  <= lcd_d;
      for (int k = 0; k < 8; k++) hex_q[k] <= hex_d[k];
    end
  end

  // Both phases count LCD_PULSE_CYC cycles: load N-1, leave on the cycle cnt reads 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (lcd_start) state_q <= S_SETUP;
        S_SETUP: begin
          cnt_q   <= CNT_LOAD;
          en_q    <= 1'b1;
          state_q <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt_q == 8'd0) begin
            cnt_q   <= CNT_LOAD;
            en_q    <= 1'b0;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q == 8'd0) state_q <= S_IDLE;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (off)
      12'h000: o_ld_data = {15'b0, ledr_q};
      12'h010: o_ld_data = {24'b0, ledg_q};
      12'h020: o_ld_data = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
      12'h024: o_ld_data = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
      12'h030: o_ld_data = {busy, 20'b0, lcd_q};
      default: o_ld_data = 32'h0;
    endcase
  end

  assign o_io_ledr = {15'b0, ledr_q};
  assign o_io_ledg = {24'b0, ledg_q};
  assign o_io_lcd  = {en_q, 20'b0, lcd_q};
  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer: directed scenarios plus random traffic, checked
// against a word-level model that tracks LCD activity by write-edge timestamps.
module tb_output_buffer;
  localparam int P = 4;

  logic        i_clk, i_rst_n, i_buf_en;
  logic [31:0] i_lsu_addr, i_st_data;
  logic [3:0]  i_bmask;
  logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

  output_buffer #(.LCD_PULSE_CYC(P)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_buf_en(i_buf_en),
    .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data), .i_bmask(i_bmask),
    .o_ld_data(o_ld_data), .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2),
    .o_io_hex3(o_io_hex3), .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5),
    .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7), .o_io_lcd(o_io_lcd)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_total = 0;

  // Model: one word per mapped register; LCD transfer tracked by the cycle of its write edge.
  logic [31:0] m_ledr, m_ledg, m_hex_lo, m_hex_hi, m_lcd;
  int cyc = 0;
  int lcd_start = -1000;

  function automatic logic m_busy(int c);
    return (c >= lcd_start) && (c <= lcd_start + 2*P);
  endfunction

  function automatic logic m_en(int c);
    return (c >= lcd_start + 1) && (c <= lcd_start + P);
  endfunction

  function automatic logic [31:0] valid_bits(logic [11:0] off);
    case (off)
      12'h000: return 32'h0001FFFF;
      12'h010: return 32'h000000FF;
      12'h020, 12'h024: return 32'h7F7F7F7F;
      12'h030: return 32'h000007FF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] off);
    case (off)
      12'h000: return m_ledr;
      12'h010: return m_ledg;
      12'h020: return m_hex_lo;
      12'h024: return m_hex_hi;
      12'h030: return {m_busy(cyc), m_lcd[30:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_ledr = 0; m_ledg = 0; m_hex_lo = 0; m_hex_hi = 0; m_lcd = 0;
    lcd_start = -1000;
  endtask

  // Applies one clock edge; cyc still holds the cycle before the edge.
  task automatic m_edge(logic en, logic [31:0] addr, logic [31:0] data, logic [3:0] mask);
    logic [11:0] off;
    logic [31:0] bm, upd;
    off = addr[11:0];
    bm  = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    if (en && off[1:0] == 2'b00) begin
      upd = (m_read(off) & ~bm) | (data & bm & valid_bits(off));
      case (off)
        12'h000: m_ledr = upd;
        12'h010: m_ledg = upd;
        12'h020: m_hex_lo = upd;
        12'h024: m_hex_hi = upd;
        12'h030: if ((mask[0] || mask[1]) && !m_busy(cyc)) begin
          m_lcd = upd & 32'h7FF;
          lcd_start = cyc + 1;
        end
        default: ;
      endcase
    end
    cyc++;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_outputs();
    check("ledr", o_io_ledr, m_ledr);
    check("ledg", o_io_ledg, m_ledg);
    check("hex_lo", {1'b0, o_io_hex3, 1'b0, o_io_hex2, 1'b0, o_io_hex1, 1'b0, o_io_hex0}, m_hex_lo);
    check("hex_hi", {1'b0, o_io_hex7, 1'b0, o_io_hex6, 1'b0, o_io_hex5, 1'b0, o_io_hex4}, m_hex_hi);
    check("lcd", o_io_lcd, {m_en(cyc), 20'b0, m_lcd[10:0]});
  endtask

  // Called at a falling edge: drive, check read-back, take the rising edge, check pins.
  task automatic step(logic en, logic [31:0] addr, logic [31:0] data, logic [3:0] mask);
    i_buf_en = en; i_lsu_addr = addr; i_st_data = data; i_bmask = mask;
    #1;
    check("ld_data", o_ld_data, m_read(addr[11:0]));
    @(posedge i_clk);
    m_edge(en, addr, data, mask);
    @(negedge i_clk);
    check_outputs();
  endtask

  logic [11:0] offs [9] = '{12'h000, 12'h010, 12'h020, 12'h024, 12'h030,
                             12'h040, 12'h022, 12'h031, 12'h7FC};

  initial begin
    i_rst_n = 1'b0; i_buf_en = 1'b0; i_lsu_addr = 0; i_st_data = 0; i_bmask = 0;
    m_reset();
    repeat (2) @(negedge i_clk);
    #1;
    check_outputs();
    i_rst_n = 1'b1;

    // Reset read-back of every offset
    for (int i = 0; i < 9; i++) step(1'b0, {20'h00007, offs[i]}, 32'h0, 4'h0);

    // LEDR full write then partial clear
    step(1'b1, 32'h00007000, 32'hFFFFFFFF, 4'hF);
    check("ledr_full", o_io_ledr, 32'h0001FFFF);
    step(1'b1, 32'h00007000, 32'h00000000, 4'h1);
    check("ledr_lane0", o_io_ledr, 32'h0001FF00);

    // HEX lanes 0 and 2
    step(1'b1, 32'h00007020, 32'h80FF4012, 4'h5);
    check("hex0", {25'b0, o_io_hex0}, 32'h12);
    check("hex2", {25'b0, o_io_hex2}, 32'h7F);
    check("hex1_hex3", {18'b0, o_io_hex1, o_io_hex3}, 32'h0);
    step(1'b0, 32'h00007020, 32'h0, 4'h0);
    check("hex_read", o_ld_data, 32'h007F0012);

    // LCD pulse timing: cycle 1 is the cycle after the write edge
    step(1'b1, 32'h00007030, 32'h00000541, 4'h3);
    check("lcd_data", {21'b0, o_io_lcd[10:0]}, 32'h541);
    check("lcd_en_c1", {31'b0, o_io_lcd[31]}, 32'h0);
    for (int i = 2; i <= 11; i++) begin
      step(1'b0, 32'h00007030, 32'h0, 4'h0);
      check("lcd_en_dir", {31'b0, o_io_lcd[31]}, {31'b0, (i >= 2 && i <= 5)});
      check("lcd_busy_dir", {31'b0, o_ld_data[31]}, {31'b0, (i <= 9)});
    end

    // Writes during PULSE and HOLD are dropped; other registers still update
    step(1'b1, 32'h00007030, 32'h00000123, 4'h3);
    step(1'b0, 32'h00007030, 32'h0, 4'h0);
    step(1'b1, 32'h00007030, 32'h000002AA, 4'h3);
    step(1'b1, 32'h00007010, 32'h000000C3, 4'h1);
    check("ledg_while_busy", o_io_ledg, 32'hC3);
    repeat (2) step(1'b0, 32'h00007030, 32'h0, 4'h0);
    step(1'b1, 32'h00007030, 32'h00000555, 4'h3);
    check("lcd_hold_drop", {21'b0, o_io_lcd[10:0]}, 32'h123);
    // Cycle 9 of this transfer: last HOLD cycle, write on the returning edge is dropped
    repeat (2) step(1'b0, 32'h00007030, 32'h0, 4'h0);
    step(1'b1, 32'h00007030, 32'h00000666, 4'h3);
    check("lcd_return_edge_drop", {21'b0, o_io_lcd[10:0]}, 32'h123);
    step(1'b1, 32'h00007030, 32'h00000777, 4'h3);
    check("lcd_after_idle", {21'b0, o_io_lcd[10:0]}, 32'h777);

    // Asynchronous reset in the middle of a pulse
    repeat (2) step(1'b0, 32'h00007030, 32'h0, 4'h0);
    check("en_before_rst", {31'b0, o_io_lcd[31]}, 32'h1);
    i_buf_en = 1'b0; i_lsu_addr = 32'h00007030;
    i_rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_en", {31'b0, o_io_lcd[31]}, 32'h0);
    check("rst_ld", o_ld_data, 32'h0);
    check_outputs();
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    m_edge(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge i_clk);
    step(1'b1, 32'h00007040, 32'hFFFFFFFF, 4'hF);
    step(1'b1, 32'h00007022, 32'hFFFFFFFF, 4'hF);
    check("unmapped_no_effect", o_io_ledr | o_io_ledg | {o_io_hex0, o_io_hex2, 18'b0}, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [11:0] o;
      o = offs[$urandom_range(0, 8)];
      step(($urandom_range(0, 3) != 0), {$urandom_range(0, 32'hFFFFF), o}, $urandom(),
           4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter LCD_PULSE_CYC, default 24, the number of cycles for the LCD EN-high phase and again for the EN-low hold phase (legal range 2..255).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_buf_en  input  1  write strobe from the LSU address decoder; asserted only for a store into 0x7000-0x7FFF.
REQ-005 SHALL have port i_lsu_addr  input  32  LSU byte address; only bits [11:0] are decoded.
REQ-006 SHALL have port i_st_data  input  32  store data.
REQ-007 SHALL have port i_bmask  input  4  byte-lane enables; bit k covers bits [8k+7:8k].
REQ-008 SHALL have port o_ld_data  output  32  combinational read-back of the addressed register.
REQ-009 SHALL have port o_io_ledr  output  32  red LEDs; bits [16:0] are used, [31:17] are tied to 0.
REQ-010 SHALL have port o_io_ledg  output  32  green LEDs; bits [7:0] are used, [31:8] are tied to 0.
REQ-011 SHALL have ports o_io_hex0 through o_io_hex7  output  7 each  seven-segment patterns.
REQ-012 SHALL have port o_io_lcd  output  32  LCD bus: [7:0] data, [8] RS, [9] RW, [10] ON, [30:11] tied to 0, [31] EN.

Function
REQ-013 SHALL perform a write on a rising edge when i_buf_en=1, using offset off=i_lsu_addr[11:0]; byte lanes with i_bmask[k]=0 keep their old value.
REQ-014 SHALL use this map: 0x000 LEDR[16:0]; 0x010 LEDG[7:0]; 0x020 HEX0..HEX3 (byte k -> HEXk, bits [6:0]); 0x024 HEX4..HEX7; 0x030 LCD[10:0].
REQ-015 SHALL treat unused bits as follows: bits above a register's width are not stored and read as 0; bit 7 of each HEX byte is not stored and reads as 0.
REQ-016 SHALL ignore writes to unmapped offsets or with off[1:0]!=0; reads of such offsets return 32'h0.
REQ-017 SHALL return o_ld_data combinationally: stored register bits zero-extended; at 0x030, bit 31 is the LCD busy flag.
REQ-018 SHALL drive the I/O outputs directly from the registers, so a write is visible on the pins in the cycle after the write edge.
REQ-019 SHALL control the LCD with FSM states IDLE, SETUP, PULSE and HOLD, using an 8-bit counter cnt.
REQ-020 SHALL, in IDLE, on an accepted LCD write (off=0x030, i_bmask[0] or i_bmask[1] set), latch the data and enter SETUP.
REQ-021 SHALL leave SETUP after exactly 1 cycle, load cnt=LCD_PULSE_CYC-1 and enter PULSE.
REQ-022 SHALL hold EN=1 in PULSE; it SHALL decrement cnt each cycle, and when cnt=0 reload cnt=LCD_PULSE_CYC-1 and enter HOLD.
REQ-023 SHALL hold EN=0 in HOLD; when cnt=0 it SHALL return to IDLE.
REQ-024 SHALL set busy=1 in any state other than IDLE; EN=1 only in PULSE.
REQ-025 SHALL drop writes to 0x030 while busy, leaving the LCD register unchanged; writes to other registers proceed normally.
REQ-026 SHALL allow an LCD write in the same cycle the FSM returns to IDLE only on the following edge, since busy is sampled from the current state.

Reset
REQ-027 SHALL, while i_rst_n=0, immediately clear all registers, o_io_* and cnt to 0, set the FSM to IDLE and set EN=0, including in the middle of a pulse.
REQ-028 SHALL, after reset is released, accept the first write on the first rising edge with i_buf_en=1.

Verification
REQ-029 Reset then read every offset -> o_ld_data=0 and all outputs 0.
REQ-030 Write 32'hFFFFFFFF to 0x000 with i_bmask=4'hF -> o_io_ledr=32'h0001FFFF; then write 32'h0 with i_bmask=4'h1 -> o_io_ledr=32'h0001FF00.
REQ-031 Write 32'h80FF4012 to 0x020 with i_bmask=4'h5 -> hex0=7'h12, hex2=7'h7F, hex1 and hex3 unchanged (0); read 0x020 returns 32'h007F0012.
REQ-032 Write 32'h00000541 to 0x030 with i_bmask=4'h3 and LCD_PULSE_CYC=4 -> next edge o_io_lcd[10:0]=11'h541, then EN=1 for cycles 2-5, EN=0 with busy=1 for cycles 6-9, busy=0 from cycle 10.
REQ-033 Second LCD write during PULSE -> LCD data unchanged and pulse timing unaffected; a write during HOLD is also dropped.
REQ-034 Assert i_rst_n=0 mid-PULSE with no clock edge -> EN=0 and busy=0 at once; writes to 0x040 and 0x022 change no state.
